// File: rtl/npc_mc_core_if.sv
// ============================================================================
//  Module      : npc_mc_core_if
//  Description : Instruction-fetch request/valid bus between core and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface npc_mc_core_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/npc_mc_core.sv
// ============================================================================
//  Module      : npc_mc_core
//  Description : Multi-cycle RV-I/RV-E integer core (FETCH/DECODE/EXEC/WB/HALT).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_mc_core #(
    parameter int          XLEN     = 64,
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  wire                  clk,
    input  wire                  rst_n,
    npc_mc_core_if.master        imem,
    output logic                 retire_o,
    output logic [31:0]          retire_pc_o,
    output logic                 halted_o,
    output logic [1:0]           trap_code_o,
    input  wire  [4:0]           dbg_addr_i,
    output logic [XLEN-1:0]      dbg_data_o
);

    localparam int c_SHW  = $clog2(XLEN);
    localparam int c_RIDX = $clog2(NREG);
    localparam int c_HIW  = 12 - c_SHW;

    localparam logic [5:0]       c_NREG    = 6'(NREG);
    localparam logic [c_HIW-1:0] c_SRA_HI  = {2'b01, {(c_HIW-2){1'b0}}};
    localparam logic [31:0]      c_EBREAK  = 32'h0010_0073;

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_WB     = 3'd3;
    localparam logic [2:0] c_ST_HALT   = 3'd4;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_SLT  = 4'd2;
    localparam logic [3:0] c_OP_SLTU = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_OR   = 4'd5;
    localparam logic [3:0] c_OP_AND  = 4'd6;
    localparam logic [3:0] c_OP_SLL  = 4'd7;
    localparam logic [3:0] c_OP_SRL  = 4'd8;
    localparam logic [3:0] c_OP_SRA  = 4'd9;
    localparam logic [3:0] c_OP_EBRK = 4'd10;

    localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OPC_SYS   = 7'b1110011;

    logic [2:0]        state_q, state_d;
    logic [31:0]       pc_q;
    logic [31:0]       ir_q;
    logic [3:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q, result_q;
    logic [c_RIDX-1:0] rd_q;
    logic              retire_q;
    logic [1:0]        trap_q;
    logic [XLEN-1:0]   rf_q [NREG];

    logic [6:0]        w_opcode;
    logic [4:0]        w_rd, w_rs1, w_rs2;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic [c_HIW-1:0]  w_sh_hi;
    logic [XLEN-1:0]   w_imm_i, w_imm_u;
    logic [XLEN-1:0]   w_rs1_val, w_rs2_val;
    logic [3:0]        w_op;
    logic [XLEN-1:0]   w_a, w_b;
    logic              w_illegal;
    logic              w_use_rs1, w_use_rs2, w_use_rd;
    logic [XLEN-1:0]   w_alu;
    logic              w_x10_nz;

    assign w_opcode = ir_q[6:0];
    assign w_rd     = ir_q[11:7];
    assign w_f3     = ir_q[14:12];
    assign w_rs1    = ir_q[19:15];
    assign w_rs2    = ir_q[24:20];
    assign w_f7     = ir_q[31:25];
    assign w_sh_hi  = ir_q[31:20+c_SHW];
    assign w_imm_i  = XLEN'($signed(ir_q[31:20]));
    assign w_imm_u  = XLEN'($signed({ir_q[31:12], 12'b0}));

    // Out-of-range indices read as zero; such encodings are trapped in DECODE anyway.
    assign w_rs1_val = (w_rs1 == 5'd0 || {1'b0, w_rs1} >= c_NREG) ? '0 : rf_q[w_rs1[c_RIDX-1:0]];
    assign w_rs2_val = (w_rs2 == 5'd0 || {1'b0, w_rs2} >= c_NREG) ? '0 : rf_q[w_rs2[c_RIDX-1:0]];
    assign w_x10_nz  = (rf_q[c_RIDX'(10)] != '0);

    // ------------------------------------------------------------------
    // Decode and operand selection
    // ------------------------------------------------------------------
    always_comb begin
        w_illegal = 1'b0;
        w_op      = c_OP_ADD;
        w_a       = '0;
        w_b       = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b1;
        case (w_opcode)
            c_OPC_OPIMM: begin
                w_use_rs1 = 1'b1;
                w_a       = w_rs1_val;
                w_b       = w_imm_i;
                case (w_f3)
                    3'b000: w_op = c_OP_ADD;
                    3'b010: w_op = c_OP_SLT;
                    3'b011: w_op = c_OP_SLTU;
                    3'b100: w_op = c_OP_XOR;
                    3'b110: w_op = c_OP_OR;
                    3'b111: w_op = c_OP_AND;
                    3'b001: begin
                        w_op      = c_OP_SLL;
                        w_illegal = (w_sh_hi != '0);
                    end
                    3'b101: begin
                        if (w_sh_hi == c_SRA_HI) begin
                            w_op = c_OP_SRA;
                        end else if (w_sh_hi == '0) begin
                            w_op = c_OP_SRL;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            c_OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_a       = w_rs1_val;
                w_b       = w_rs2_val;
                if (w_f3 == 3'b000 && w_f7 == 7'b0000000) begin
                    w_op = c_OP_ADD;
                end else if (w_f3 == 3'b000 && w_f7 == 7'b0100000) begin
                    w_op = c_OP_SUB;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OPC_LUI: begin
                w_b = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_a = XLEN'(pc_q);
                w_b = w_imm_u;
            end
            c_OPC_SYS: begin
                w_use_rd  = 1'b0;
                w_op      = c_OP_EBRK;
                w_illegal = (ir_q != c_EBREAK);
            end
            default: w_illegal = 1'b1;
        endcase
        if ((w_use_rd  && {1'b0, w_rd}  >= c_NREG) ||
            (w_use_rs1 && {1'b0, w_rs1} >= c_NREG) ||
            (w_use_rs2 && {1'b0, w_rs2} >= c_NREG)) begin
            w_illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = a_q + b_q;
        case (op_q)
            c_OP_SUB:  w_alu = a_q - b_q;
            c_OP_SLT:  w_alu = XLEN'($signed(a_q) < $signed(b_q));
            c_OP_SLTU: w_alu = XLEN'(a_q < b_q);
            c_OP_XOR:  w_alu = a_q ^ b_q;
            c_OP_OR:   w_alu = a_q | b_q;
            c_OP_AND:  w_alu = a_q & b_q;
            c_OP_SLL:  w_alu = a_q << b_q[c_SHW-1:0];
            c_OP_SRL:  w_alu = a_q >> b_q[c_SHW-1:0];
            c_OP_SRA:  w_alu = $signed(a_q) >>> b_q[c_SHW-1:0];
            default:   ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_FETCH:  if (imem.imem_valid) state_d = c_ST_DECODE;
            c_ST_DECODE: state_d = w_illegal ? c_ST_HALT : c_ST_EXEC;
            c_ST_EXEC:   state_d = (op_q == c_OP_EBRK) ? c_ST_HALT : c_ST_WB;
            c_ST_WB:     state_d = c_ST_FETCH;
            c_ST_HALT:   state_d = c_ST_HALT;
            default:     state_d = c_ST_FETCH;
        endcase
    end

    // The request is gated by rst_n so it falls the instant reset asserts.
    always_comb begin
        imem.imem_req  = rst_n && (state_q == c_ST_FETCH);
        imem.imem_addr = pc_q;
        halted_o       = (state_q == c_ST_HALT);
        retire_o       = retire_q;
        retire_pc_o    = pc_q;
        trap_code_o    = trap_q;
        dbg_data_o     = (dbg_addr_i == 5'd0 || {1'b0, dbg_addr_i} >= c_NREG)
                         ? '0 : rf_q[dbg_addr_i[c_RIDX-1:0]];
    end

    // ------------------------------------------------------------------
    // Datapath and register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            op_q     <= c_OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            rd_q     <= '0;
            retire_q <= 1'b0;
            trap_q   <= 2'd0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                c_ST_FETCH: begin
                    if (imem.imem_valid) ir_q <= imem.imem_rdata;
                end
                c_ST_DECODE: begin
                    op_q <= w_op;
                    a_q  <= w_a;
                    b_q  <= w_b;
                    rd_q <= w_use_rd ? w_rd[c_RIDX-1:0] : '0;
                    if (w_illegal) trap_q <= 2'd2;
                end
                c_ST_EXEC: begin
                    // EBREAK retires from EXEC so its pulse lands in the first HALT cycle.
                    retire_q <= 1'b1;
                    if (op_q == c_OP_EBRK) begin
                        trap_q <= {1'b0, w_x10_nz};
                    end else begin
                        result_q <= w_alu;
                    end
                end
                c_ST_WB: begin
                    if (rd_q != '0) rf_q[rd_q] <= result_q;
                    pc_q <= pc_q + 32'd4;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_npc_mc_core.sv
// ============================================================================
//  Module      : tb_npc_mc_core
//  Description : Directed self-checking bench for npc_mc_core (RV-I and RV-E).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_npc_mc_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        retire, halted, retire16, halted16;
    logic [31:0] retire_pc, retire_pc16;
    logic [1:0]  trap, trap16;
    logic [4:0]  dbg_addr, dbg_addr16;
    logic [63:0] dbg_data, dbg_data16;
    int          checks = 0;
    int          errors = 0;

    npc_mc_core_if bus ();
    npc_mc_core_if bus16 ();

    always #5 clk = ~clk;

    npc_mc_core #(.XLEN(64), .NREG(32), .RESET_PC(32'h8000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem(bus),
        .retire_o(retire), .retire_pc_o(retire_pc), .halted_o(halted),
        .trap_code_o(trap), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
    );

    npc_mc_core #(.XLEN(64), .NREG(16), .RESET_PC(32'h8000_0000)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .imem(bus16),
        .retire_o(retire16), .retire_pc_o(retire_pc16), .halted_o(halted16),
        .trap_code_o(trap16), .dbg_addr_i(dbg_addr16), .dbg_data_o(dbg_data16)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_valid   = 1'b0;
        bus16.imem_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Feed one instruction to the main core; lat counts cycles from the first
    // FETCH cycle to the cycle retire (or halted) is seen; ends one cycle later.
    task automatic run_instr(input logic [31:0] instr, input int dly,
                             output int lat, output logic seen, output logic [31:0] rpc);
        int k;
        lat = 0; seen = 1'b0; rpc = '0; k = 0;
        while (bus.imem_req !== 1'b1 && k < 20) begin
            @(negedge clk); k++;
        end
        if (bus.imem_req !== 1'b1) begin
            checks++; errors++;
            $display("FAIL fetch_timeout req=%0b required=1", bus.imem_req);
            return;
        end
        lat = 1;
        repeat (dly) begin
            @(negedge clk); lat++;
        end
        bus.imem_rdata = instr;
        bus.imem_valid = 1'b1;
        @(negedge clk); lat++;
        bus.imem_valid = 1'b0;
        k = 0;
        while (retire !== 1'b1 && halted !== 1'b1 && k < 8) begin
            @(negedge clk); lat++; k++;
        end
        seen = (retire === 1'b1);
        rpc  = retire_pc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; #1;
        rst_n = 1'b0; #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req actual=%0b required=0", bus.imem_req); end
        checks++; if (retire !== 1'b0) begin errors++; $display("FAIL rst_retire actual=%0b required=0", retire); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted actual=%0b required=0", halted); end
        checks++; if (trap !== 2'd0) begin errors++; $display("FAIL rst_trap actual=%0d required=0", trap); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rel_req actual=%0b required=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL rel_addr actual=%h required=80000000", bus.imem_addr); end
        dbg_addr = 5'd1; #1;
        checks++; if (dbg_data !== 64'd0) begin errors++; $display("FAIL rst_x1 actual=%h required=0", dbg_data); end
    endtask

    task automatic test_first_addi();
        int lat; logic seen; logic [31:0] rpc;
        run_instr(32'h0050_0093, 0, lat, seen, rpc);
        checks++; if (seen !== 1'b1 || lat != 4) begin errors++; $display("FAIL addi_latency actual=%0d seen=%0b required=4", lat, seen); end
        checks++; if (rpc !== 32'h8000_0000) begin errors++; $display("FAIL addi_rpc actual=%h required=80000000", rpc); end
        dbg_addr = 5'd1; #1;
        checks++; if (dbg_data !== 64'd5) begin errors++; $display("FAIL addi_x1 actual=%h required=5", dbg_data); end
        checks++; if (bus.imem_addr !== 32'h8000_0004 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL addi_next_addr actual=%h required=80000004", bus.imem_addr); end
    endtask

    task automatic test_shifts();
        int lat; logic seen; logic [31:0] rpc;
        logic [31:0] prog [4] = '{32'h FFF0_0093, 32'h03C0_D113, 32'h43C0_D193, 32'h03F0_9213};
        logic [63:0] expv [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        for (int i = 0; i < 4; i++) begin
            run_instr(prog[i], 0, lat, seen, rpc);
            dbg_addr = 5'(i + 1); #1;
            checks++;
            if (seen !== 1'b1 || dbg_data !== expv[i]) begin
                errors++; $display("FAIL shift_x%0d actual=%h seen=%0b required=%h", i + 1, dbg_data, seen, expv[i]);
            end
        end
    endtask

    task automatic test_x0_delay();
        int lat; logic seen; logic [31:0] rpc;
        run_instr(32'h0070_0013, 3, lat, seen, rpc);
        checks++; if (seen !== 1'b1 || lat != 7) begin errors++; $display("FAIL x0_latency actual=%0d seen=%0b required=7", lat, seen); end
        dbg_addr = 5'd0; #1;
        checks++; if (dbg_data !== 64'd0) begin errors++; $display("FAIL x0_value actual=%h required=0", dbg_data); end
    endtask

    task automatic test_lui_auipc();
        int lat; logic seen; logic [31:0] rpc;
        do_reset();
        run_instr(32'h8000_02B7, 0, lat, seen, rpc);
        run_instr(32'h0000_0013, 0, lat, seen, rpc);
        run_instr(32'h0000_1317, 0, lat, seen, rpc);
        checks++; if (seen !== 1'b1 || rpc !== 32'h8000_0008) begin errors++; $display("FAIL auipc_rpc actual=%h required=80000008", rpc); end
        dbg_addr = 5'd5; #1;
        checks++; if (dbg_data !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL lui_x5 actual=%h required=ffffffff80000000", dbg_data); end
        dbg_addr = 5'd6; #1;
        checks++; if (dbg_data !== 64'h0000_0000_8000_1008) begin errors++; $display("FAIL auipc_x6 actual=%h required=80001008", dbg_data); end
    endtask

    task automatic test_alu();
        int lat; logic seen; logic [31:0] rpc;
        logic [31:0] prog [7] = '{32'h0030_0393, 32'h4070_0433, 32'h0054_3493, 32'h0054_2593,
                                  32'hFFF3_C613, 32'h0083_86B3, 32'h0103_E713};
        logic [4:0]  rdv  [7] = '{5'd7, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        logic [63:0] expv [7] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd1,
                                  64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'h13};
        for (int i = 0; i < 7; i++) begin
            run_instr(prog[i], 0, lat, seen, rpc);
            dbg_addr = rdv[i]; #1;
            checks++;
            if (seen !== 1'b1 || dbg_data !== expv[i]) begin
                errors++; $display("FAIL alu_x%0d actual=%h seen=%0b required=%h", rdv[i], dbg_data, seen, expv[i]);
            end
        end
    endtask

    task automatic test_ebreak();
        int lat; logic seen; logic [31:0] rpc; int pulses;
        logic [31:0] setup [2] = '{32'h0000_0513, 32'h0030_0513};
        for (int t = 0; t < 2; t++) begin
            do_reset();
            run_instr(setup[t], 0, lat, seen, rpc);
            run_instr(32'h0010_0073, 0, lat, seen, rpc);
            checks++; if (seen !== 1'b1 || rpc !== 32'h8000_0004) begin errors++; $display("FAIL ebreak_retire_%0d actual=%h seen=%0b required=80000004", t, rpc, seen); end
            checks++; if (halted !== 1'b1 || trap !== 2'(t)) begin errors++; $display("FAIL ebreak_trap_%0d actual=%0d halted=%0b required=%0d", t, trap, halted, t); end
            // A stray valid while halted must not revive the core.
            pulses = 0;
            bus.imem_rdata = 32'h0050_0093;
            bus.imem_valid = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (retire === 1'b1 || bus.imem_req !== 1'b0 || halted !== 1'b1) pulses++;
            end
            bus.imem_valid = 1'b0;
            dbg_addr = 5'd1; #1;
            checks++; if (pulses != 0 || dbg_data !== 64'd0) begin errors++; $display("FAIL halt_sticky_%0d actual=%0d x1=%h required=0", t, pulses, dbg_data); end
        end
    endtask

    task automatic test_illegal();
        int lat; logic seen; logic [31:0] rpc;
        logic [31:0] bad [2] = '{32'hFFFF_FFFF, 32'h83C0_D193};
        for (int t = 0; t < 2; t++) begin
            do_reset();
            run_instr(bad[t], 0, lat, seen, rpc);
            checks++; if (seen !== 1'b0) begin errors++; $display("FAIL illegal_retire_%0d actual=%0b required=0", t, seen); end
            checks++; if (halted !== 1'b1 || trap !== 2'd2) begin errors++; $display("FAIL illegal_trap_%0d actual=%0d halted=%0b required=2", t, trap, halted); end
        end
        dbg_addr = 5'd3; #1;
        checks++; if (dbg_data !== 64'd0) begin errors++; $display("FAIL illegal_nowrite actual=%h required=0", dbg_data); end
    endtask

    task automatic test_rve();
        logic [31:0] prog [2] = '{32'h0090_0793, 32'h0010_0A13};
        int k;
        do_reset();
        for (int t = 0; t < 2; t++) begin
            k = 0;
            while (bus16.imem_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
            bus16.imem_rdata = prog[t];
            bus16.imem_valid = 1'b1;
            @(negedge clk);
            bus16.imem_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
        dbg_addr16 = 5'd15; #1;
        checks++; if (dbg_data16 !== 64'd9) begin errors++; $display("FAIL rve_x15 actual=%h required=9", dbg_data16); end
        checks++; if (halted16 !== 1'b1 || trap16 !== 2'd2) begin errors++; $display("FAIL rve_x20_trap actual=%0d halted=%0b required=2", trap16, halted16); end
    endtask

    task automatic test_reset_mid();
        int lat; logic seen; logic [31:0] rpc; int pulses;
        do_reset();
        run_instr(32'h0050_0093, 0, lat, seen, rpc);
        #2 rst_n = 1'b0;
        #1;
        dbg_addr = 5'd1; #1;
        checks++; if (bus.imem_req !== 1'b0 || dbg_data !== 64'd0) begin errors++; $display("FAIL midfetch_async req=%0b x1=%h required=0", bus.imem_req, dbg_data); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        checks++; if (bus.imem_addr !== 32'h8000_0000 || halted !== 1'b0 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL midfetch_restart actual=%h halted=%0b required=80000000", bus.imem_addr, halted); end
        // Abandon an instruction already in DECODE.
        bus.imem_rdata = 32'h0090_0113;
        bus.imem_valid = 1'b1;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        rst_n = 1'b0;
        pulses = 0;
        repeat (2) begin @(negedge clk); if (retire === 1'b1) pulses++; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (retire === 1'b1) pulses++; end
        dbg_addr = 5'd2; #1;
        checks++; if (pulses != 0 || dbg_data !== 64'd0) begin errors++; $display("FAIL midinstr_abandon actual=%0d x2=%h required=0", pulses, dbg_data); end
    endtask

    initial begin
        rst_n = 1'b1;
        dbg_addr = 5'd0;
        dbg_addr16 = 5'd0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        bus16.imem_valid = 1'b0;
        bus16.imem_rdata = '0;
        #2;
        test_reset();
        test_first_addi();
        test_shifts();
        test_x0_delay();
        test_lui_auipc();
        test_alu();
        test_ebreak();
        test_illegal();
        test_rve();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/npc_mc_core.md
# npc_mc_core

Multi-cycle integer core, next generation of the NPC single-cycle datapath. Fetches 32-bit RISC-V instructions over a request/valid instruction port, decodes, executes on an XLEN-wide ALU and writes back to an internal register file; halts on EBREAK or on an illegal encoding. Sits directly under the simulation top, with instruction memory outside the core.

## Interface
- XLEN, 64: datapath and register width; legal values 32, 64.
- NREG, 32: architectural register count; 32 (RV-I) or 16 (RV-E).
- RESET_PC, 32'h8000_0000: PC loaded on reset.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_req  out  1  fetch request; held high until imem_valid.
- imem_addr  out  32  fetch address (current PC), stable while imem_req high.
- imem_valid  in  1  imem_rdata valid this cycle; ignored unless imem_req high.
- imem_rdata  in  32  instruction word.
- retire  out  1  one-cycle pulse per committed instruction.
- retire_pc  out  32  PC of the retiring instruction, valid with retire.
- halted  out  1  core stopped; sticky until reset.
- trap_code  out  2  0 good trap, 1 bad trap, 2 illegal instruction; valid while halted.
- dbg_addr  in  5  register read address for the bench.
- dbg_data  out  XLEN  combinational read of register dbg_addr (0 for x0 or address >= NREG).

## Operation
- FSM states: FETCH, DECODE, EXEC, WB, HALT.
- FETCH: imem_req=1, imem_addr=pc; on imem_valid latch instruction into ir, go DECODE. Any number of wait cycles allowed.
- DECODE: read rs1/rs2, form immediate (I: sign-extended ir[31:20]; U: ir[31:12]<<12, sign-extended to XLEN); classify. Illegal encoding, or any rd/rs1/rs2 index >= NREG -> HALT, trap_code=2, no register write, no retire.
- EXEC: ALU result into result register. Supported: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, LUI, AUIPC, EBREAK.
- Shift amount: low log2(XLEN) bits of the shift field; XLEN=32 with imm[5]=1 on a shift-immediate is illegal. SRAI requires imm[11:6]=6'b010000 (64) / imm[11:5]=7'b0100000 (32), SLLI/SRLI require those bits zero, else illegal.
- Arithmetic modulo 2^XLEN, carry discarded; SLT/SLTIU produce 0 or 1 zero-extended.
- AUIPC: zero-extended pc plus U-immediate.
- WB: write result to rd unless rd==0 (x0 always reads 0); pc<=pc+4 (mod 2^32); retire pulses with retire_pc=old pc; go FETCH.
- EBREAK: in EXEC go HALT; trap_code=0 if x10==0 else 1; retire pulses once for the EBREAK; no register write.
- HALT: imem_req=0, no further state change until rst_n low.

## Timing
- Reset (rst_n low, asynchronous): state FETCH, pc=RESET_PC, imem_req=0 during reset then 1 in first cycle after release, retire=0, halted=0, trap_code=0, all registers 0.
- Reset mid-fetch or mid-instruction abandons it: no write, no retire; imem_req drops asynchronously.
- Instruction latency with imem_valid on the first request cycle: 4 cycles FETCH->next FETCH; retire asserted in the WB cycle (registered, visible on the cycle after EXEC).
- imem_valid arriving while imem_req low has no effect.
- Register write in WB visible on dbg_data from the next cycle; operand read in DECODE of the following instruction sees it (no hazard possible in multi-cycle flow).
- halted rises the cycle after EXEC of EBREAK or after DECODE of an illegal instruction, together with trap_code.

## Test plan
- Reset release, memory returns ADDI x1,x0,5 (0x00500093) immediately -> retire at cycle 4 with retire_pc=0x80000000, dbg x1=5, next imem_addr=0x80000004.
- ADDI x1,x0,-1 then SRLI x2,x1,60 (XLEN=64) -> x1=0xFFFF_FFFF_FFFF_FFFF, x2=0xF; SRAI x3,x1,60 -> x3 all ones.
- ADDI x0,x0,7 -> x0 reads 0, retire still pulses; 3-cycle imem_valid delay stretches FETCH, total 7 cycles.
- LUI x5,0x80000 (XLEN=64) -> x5=0xFFFF_FFFF_8000_0000; AUIPC x6,1 at pc 0x80000008 -> x6=0x0000_0000_8000_1008.
- ADDI x10,x0,0 then EBREAK -> halted=1, trap_code=0, imem_req stays 0; repeat with x10=3 -> trap_code=1.
- Word 0xFFFFFFFF -> halted, trap_code=2, no retire; NREG=16 with ADDI x20,x0,1 -> trap_code=2; assert rst_n low mid-FETCH -> pc back to 0x80000000, halted=0.
